// File: rtl/seven_seg_counter.sv
// Multi-digit up/down counter driven by three debounced push switches, with a
// registered seven-segment drive for every digit and overflow/underflow pulses.
module seven_seg_counter #(
    parameter int NUM_DIGITS     = 2,
    parameter int RADIX          = 16,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int WRAP_MODE      = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_Switch_Up,
    input  logic                      i_Switch_Down,
    input  logic                      i_Switch_Clear,
    output logic [4*NUM_DIGITS-1:0]   o_Count,
    output logic [7*NUM_DIGITS-1:0]   o_Segments,
    output logic                      o_Overflow,
    output logic                      o_Underflow
);

    localparam int              CW        = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic [3:0]      DIGIT_MAX = 4'(RADIX - 1);
    localparam int              CNT_W     = 4 * NUM_DIGITS;

    localparam int SW_UP    = 0;
    localparam int SW_DOWN  = 1;
    localparam int SW_CLEAR = 2;

    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'b0111111;
            4'h1:    pattern = 7'b0000110;
            4'h2:    pattern = 7'b1011011;
            4'h3:    pattern = 7'b1001111;
            4'h4:    pattern = 7'b1100110;
            4'h5:    pattern = 7'b1101101;
            4'h6:    pattern = 7'b1111101;
            4'h7:    pattern = 7'b0000111;
            4'h8:    pattern = 7'b1111111;
            4'h9:    pattern = 7'b1101111;
            4'hA:    pattern = 7'b1110111;
            4'hB:    pattern = 7'b1111100;
            4'hC:    pattern = 7'b0111001;
            4'hD:    pattern = 7'b1011110;
            4'hE:    pattern = 7'b1111001;
            default: pattern = 7'b1110001;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
    endfunction

    logic [2:0]    raw_p0;
    logic [CW-1:0] db_cnt_p0 [3];
    logic [2:0]    db_state_p0;
    logic [2:0]    db_prev_p1;
    logic [2:0]    press_p1;

    logic [CNT_W-1:0] inc_p1;
    logic [CNT_W-1:0] dec_p1;
    logic             at_max_p1;
    logic             at_zero_p1;
    logic             carry;
    logic             borrow;
    logic [3:0]       digit;

    assign raw_p0 = {i_Switch_Clear, i_Switch_Down, i_Switch_Up};

    // Stage 0: per-switch debounce; the raw level must persist DEBOUNCE_LIMIT cycles
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int i = 0; i < 3; i++) db_cnt_p0[i] <= '0;
            db_state_p0 <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (raw_p0[i] == db_state_p0[i]) begin
                    db_cnt_p0[i] <= '0;
                end else if (db_cnt_p0[i] == CNT_LAST) begin
                    db_state_p0[i] <= raw_p0[i];
                    db_cnt_p0[i]   <= '0;
                end else begin
                    db_cnt_p0[i] <= db_cnt_p0[i] + 1'b1;
                end
            end
        end
    end

    // Stage 1: registered rising-edge detect of the debounced levels
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            db_prev_p1 <= '0;
            press_p1   <= '0;
        end else begin
            db_prev_p1 <= db_state_p0;
            press_p1   <= db_state_p0 & ~db_prev_p1;
        end
    end

    // Full carry/borrow ripple across all digits, settled within one cycle
    always_comb begin
        inc_p1     = o_Count;
        dec_p1     = o_Count;
        carry      = 1'b1;
        borrow     = 1'b1;
        at_max_p1  = 1'b1;
        at_zero_p1 = 1'b1;
        digit      = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            digit = o_Count[4*d +: 4];
            if (digit != DIGIT_MAX) at_max_p1  = 1'b0;
            if (digit != 4'd0)      at_zero_p1 = 1'b0;
            if (carry) begin
                if (digit == DIGIT_MAX) begin
                    inc_p1[4*d +: 4] = 4'd0;
                end else begin
                    inc_p1[4*d +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digit == 4'd0) begin
                    dec_p1[4*d +: 4] = DIGIT_MAX;
                end else begin
                    dec_p1[4*d +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Stage 2: apply the event; clear wins, simultaneous up and down cancel
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Count     <= '0;
            o_Overflow  <= 1'b0;
            o_Underflow <= 1'b0;
        end else begin
            o_Overflow  <= 1'b0;
            o_Underflow <= 1'b0;
            if (press_p1[SW_CLEAR]) begin
                o_Count <= '0;
            end else if (press_p1[SW_UP] && !press_p1[SW_DOWN]) begin
                if (at_max_p1) o_Overflow <= 1'b1;
                if (!(at_max_p1 && WRAP_MODE == 0)) o_Count <= inc_p1;
            end else if (press_p1[SW_DOWN] && !press_p1[SW_UP]) begin
                if (at_zero_p1) o_Underflow <= 1'b1;
                if (!(at_zero_p1 && WRAP_MODE == 0)) o_Count <= dec_p1;
            end
        end
    end

    // Stage 3: segment drive trails the count by one cycle
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int d = 0; d < NUM_DIGITS; d++) o_Segments[7*d +: 7] <= seg_encode(4'd0);
        end else begin
            for (int d = 0; d < NUM_DIGITS; d++) o_Segments[7*d +: 7] <= seg_encode(o_Count[4*d +: 4]);
        end
    end

endmodule

// File: doc/seven_seg_counter.md
SEVEN_SEG_COUNTER -- requirements
Module: seven_seg_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 2: number of 4-bit counter digits and 7-segment digits; legal range 1..8.
REQ-002 Parameter RADIX, default 16: per-digit radix; legal values 10 (BCD) or 16 (hex).
REQ-003 Parameter DEBOUNCE_LIMIT, default 250000: consecutive clock cycles a raw switch level must differ from its debounced state before that state changes.
REQ-004 Parameter WRAP_MODE, default 1: 1 means wrap at the limits; 0 means saturate at the limits.
REQ-005 Parameter SEG_ACTIVE_LOW, default 1: 1 means segment outputs are inverted (a lit segment drives 0).
REQ-006 i_Clk  input  1  single system clock; all logic is on its rising edge.
REQ-007 i_Reset  input  1  synchronous, active-high reset.
REQ-008 i_Switch_Up  input  1  raw switch (1 = pressed); each press increments the count.
REQ-009 i_Switch_Down  input  1  raw switch (1 = pressed); each press decrements the count.
REQ-010 i_Switch_Clear  input  1  raw switch (1 = pressed); each press clears the count to 0.
REQ-011 o_Count  output  4*NUM_DIGITS  registered count; digit d occupies bits [4d+3:4d], and digit 0 is least significant.
REQ-012 o_Segments  output  7*NUM_DIGITS  registered segment drive; digit d occupies bits [7d+6:7d] in the order {G,F,E,D,C,B,A}, with A at the LSB.
REQ-013 o_Overflow  output  1  one-cycle pulse when an increment is applied at the maximum count.
REQ-014 o_Underflow  output  1  one-cycle pulse when a decrement is applied at count 0.

Function
REQ-015 Debouncing:
- Each switch has an independent debounce counter and a debounced state.
- While the raw level differs from the debounced state, the counter increments.
- When the counter reaches DEBOUNCE_LIMIT-1, the debounced state takes the raw level and the counter clears.
- Whenever the raw level equals the debounced state, the counter clears.
REQ-016 Press detection: a press event is a single-cycle pulse, generated in the cycle after a debounced state goes from 0 to 1 (registered edge detect); releases generate no event.
REQ-017 Event priority within one cycle:
- Clear beats Up and Down.
- Up and Down together cancel: count unchanged, no flag pulse.
REQ-018 Increment:
- Digit 0 adds 1.
- Any digit at RADIX-1 that receives a carry becomes 0 and passes the carry upward.
- The whole ripple resolves in the same clock edge.
REQ-019 Decrement: the mirror of increment; any digit at 0 that receives a borrow becomes RADIX-1 and passes the borrow upward, resolved in the same edge.
REQ-020 Maximum count: every digit equals RADIX-1 (for example 0x99 when RADIX=10, or 0xFF when RADIX=16, with NUM_DIGITS=2).
REQ-021 Increment at maximum:
- WRAP_MODE=1: count becomes all zeros.
- WRAP_MODE=0: count holds at maximum.
- Either mode: o_Overflow pulses high for exactly 1 cycle, aligned with the o_Count update edge.
REQ-022 Decrement at 0:
- WRAP_MODE=1: count becomes maximum.
- WRAP_MODE=0: count holds at 0.
- Either mode: o_Underflow pulses high for exactly 1 cycle, aligned with the o_Count update edge.
REQ-023 Clear: all digits become 0 on the edge after the press event; no flag pulses.
REQ-024 Digit range: with RADIX=10, no digit ever leaves the range 0..9.
REQ-025 Segment encoding (active-high form, {G..A}):
- 0=0111111, 1=0000110, 2=1011011, 3=1001111
- 4=1100110, 5=1101101, 6=1111101, 7=0000111
- 8=1111111, 9=1101111, A=1110111, b=1111100
- C=0111001, d=1011110, E=1111001, F=1110001
- When SEG_ACTIVE_LOW=1, every bit is inverted.
REQ-026 Latency:
- o_Count updates on the edge after the press-event cycle.
- o_Segments reflects the new o_Count exactly 1 cycle later.
- From the debounced rising edge to the o_Count update is 2 cycles.
REQ-027 Concurrent presses: presses on different switches whose events fall in different cycles are each applied in order; none is lost.

Reset
REQ-028 On any clock edge with i_Reset=1, the following all reset:
- o_Count = 0.
- o_Overflow = 0 and o_Underflow = 0.
- All debounce counters = 0 and all debounced states = 0.
- All edge-detect registers = 0.
- o_Segments = the encoding of "0" on every digit, polarity applied per SEG_ACTIVE_LOW.
REQ-029 Reset overrides any pending or simultaneous event; a reset asserted mid-debounce discards the partial count.
REQ-030 A switch held at 1 through the release of reset produces exactly one press event, DEBOUNCE_LIMIT+1 cycles after reset deasserts.

Verification (bench uses DEBOUNCE_LIMIT=4, NUM_DIGITS=2)
REQ-031 Scenario: RADIX=16, WRAP_MODE=1; 17 clean Up presses from reset. Required: o_Count=0x11, and o_Segments equals the inverted pattern of "1" on both digits.
REQ-032 Scenario: RADIX=10, WRAP_MODE=1.
- Count at 0x99, one Up press: o_Count=0x00, with o_Overflow high for 1 cycle.
- Then one Down press: o_Count=0x99, with o_Underflow high for 1 cycle.
REQ-033 Scenario: RADIX=10, WRAP_MODE=0.
- Count at 0x99, Up press: o_Count stays 0x99 and o_Overflow pulses.
- Count at 0x00, Down press: o_Count stays 0x00 and o_Underflow pulses.
REQ-034 Scenario: bounce the Up input (toggle every 2 cycles for 20 cycles), then hold it high. Required: exactly one increment, with o_Count changing 6 cycles after the stable-high start.
REQ-035 Scenario: Up and Down events land in the same cycle. Required: o_Count unchanged and no flag pulse. Clear together with Up: o_Count=0.
REQ-036 Scenario: assert i_Reset for 1 cycle with count 0x37 while an Up press is mid-debounce. Required: o_Count=0x00 on the next edge, and no increment before a fresh 4-cycle stable period completes.
